// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single-word CPU-side requests into APB SETUP/ACCESS transfers,
// decodes one PSEL per slave slot, and reports decode errors and PREADY timeouts.
module apb_master_bridge #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     req,
  input  logic [31:0]              addr,
  input  logic                     we,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic                     busy,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  input  logic [32*NUM_SLAVES-1:0] PRDATA_bus,
  input  logic [NUM_SLAVES-1:0]    PREADY_bus
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  penable_q, penable_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [3:0]            slot_q, slot_d;
  logic [CW-1:0]         wait_q, wait_d;

  logic                  hit_c;
  logic [NUM_SLAVES-1:0] req_sel_c;
  logic                  sel_ready_c;
  logic [31:0]           sel_rdata_c;

  // Request address decode into region hit and one-hot slot select
  always_comb begin
    hit_c = (addr[31:16] == BASE_ADDR[31:16]) && (32'(addr[15:12]) < NUM_SLAVES);
    for (int s = 0; s < NUM_SLAVES; s++) begin
      req_sel_c[s] = (addr[15:12] == 4'(s));
    end
  end

  // Only the latched slot's PREADY/PRDATA are observed
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = 32'd0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (slot_q == 4'(s)) begin
        sel_ready_c = PREADY_bus[s];
        sel_rdata_c = PRDATA_bus[32*s +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    slot_d    = slot_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_c) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = we;
            slot_d   = addr[15:12];
            psel_d   = req_sel_c;
            state_d  = SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready_c) begin
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? 32'd0 : sel_rdata_c;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          // Slave never answered: complete with error so the core is not stalled forever
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = 32'd0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      pwrite_q  <= 1'b0;
      slot_q    <= 4'd0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      wait_q    <= '0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      slot_q    <= slot_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios with literal expectations plus
// randomized transfers checked every cycle against a transaction-level model.
module tb_apb_master_bridge;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              req = 1'b0;
  logic [31:0]       addr = 32'd0;
  logic              we = 1'b0;
  logic [31:0]       wdata = 32'd0;
  logic [31:0]       rdata;
  logic              ready, err, busy;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [32*NS-1:0]  PRDATA_bus = '0;
  logic [NS-1:0]     PREADY_bus;

  logic [NS-1:0]     slv_q;
  logic [NS-1:0]     rnd_rdy = '0;
  int                mode = 0;   // 0 tied high, 1 registered slave, 2 never ready, 3 random
  logic              rnd_en = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  apb_master_bridge #(
    .NUM_SLAVES(NS),
    .BASE_ADDR (32'h1000_0000),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (req),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .err       (err),
    .busy      (busy),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA_bus(PRDATA_bus),
    .PREADY_bus(PREADY_bus)
  );

  always #5 PCLK = ~PCLK;

  // Slave that answers one cycle after seeing PSEL & PENABLE
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) slv_q <= '0;
    else        slv_q <= PSEL & {NS{PENABLE}};
  end

  assign PREADY_bus = (mode == 0) ? {NS{1'b1}} :
                      (mode == 1) ? slv_q :
                      (mode == 2) ? {NS{1'b0}} : rnd_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
  endtask

  // Transaction-level reference: one outstanding transfer, counted in edges since acceptance
  logic          m_busy = 1'b0;
  int            m_k = 0;
  int            m_slot = 0;
  logic [31:0]   m_paddr = 32'd0, m_pwdata = 32'd0, m_rdata = 32'd0;
  logic          m_pwrite = 1'b0, m_ready = 1'b0, m_err = 1'b0;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_busy = 1'b0; m_k = 0; m_slot = 0;
      m_paddr = 32'd0; m_pwdata = 32'd0; m_rdata = 32'd0;
      m_pwrite = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    end else begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (!m_busy) begin
        if (req) begin
          if (addr[31:16] == 16'h1000 && int'(addr[15:12]) < NS) begin
            m_busy = 1'b1; m_k = 0; m_slot = int'(addr[15:12]);
            m_paddr = addr; m_pwdata = wdata; m_pwrite = we;
          end else begin
            m_ready = 1'b1; m_err = 1'b1; m_rdata = 32'd0;
          end
        end
      end else if (m_k == 0) begin
        m_k = 1;
      end else if (PREADY_bus[m_slot]) begin
        m_ready = 1'b1;
        m_rdata = m_pwrite ? 32'd0 : PRDATA_bus[32*m_slot +: 32];
        m_busy  = 1'b0;
      end else if (m_k == int'(TO)) begin
        m_ready = 1'b1; m_err = 1'b1; m_rdata = 32'd0; m_busy = 1'b0;
      end else begin
        m_k++;
      end
    end
  end

  always @(negedge PCLK) begin
    logic [NS-1:0] one;
    logic [NS-1:0] want_psel;
    one = 1;
    want_psel = m_busy ? (one << m_slot) : '0;
    chk("m_ready",   32'(ready),   32'(m_ready));
    chk("m_err",     32'(err),     32'(m_err));
    chk("m_rdata",   rdata,        m_rdata);
    chk("m_busy",    32'(busy),    32'(m_busy));
    chk("m_psel",    32'(PSEL),    32'(want_psel));
    chk("m_penable", 32'(PENABLE), 32'(m_busy && m_k > 0));
    chk("m_paddr",   PADDR,        m_paddr);
    chk("m_pwdata",  PWDATA,       m_pwdata);
    chk("m_pwrite",  32'(PWRITE),  32'(m_pwrite));
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
    if (rnd_en) begin
      for (int s = 0; s < int'(NS); s++) PRDATA_bus[32*s +: 32] = $urandom;
      rnd_rdy = NS'($urandom);
    end
  endtask

  int          sel, n, cnt;
  logic [31:0] a;

  initial begin
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #2;
    chk("rst_psel",  32'(PSEL),    32'd0);
    chk("rst_pen",   32'(PENABLE), 32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_ready", 32'(ready),   32'd0);
    chk("rst_paddr", PADDR,        32'd0);
    chk("rst_rdata", rdata,        32'd0);
    #1 PRESET = 1'b0;

    // Write to slot 0 through a registered-PREADY slave: ready on edge 4
    mode = 1; req = 1; addr = 32'h1000_0004; we = 1; wdata = 32'h0000_00FF;
    tick(); req = 0;
    chk("t1_setup_psel", 32'(PSEL), 32'h1);
    chk("t1_setup_pen",  32'(PENABLE), 32'd0);
    chk("t1_paddr",      PADDR, 32'h1000_0004);
    tick();
    chk("t1_acc1_pen",   32'(PENABLE), 32'd1);
    chk("t1_acc1_rdy",   32'(ready), 32'd0);
    tick();
    chk("t1_acc2_pen",   32'(PENABLE), 32'd1);
    chk("t1_pwdata",     PWDATA, 32'h0000_00FF);
    tick();
    chk("t1_ready",      32'(ready), 32'd1);
    chk("t1_err",        32'(err), 32'd0);
    chk("t1_psel_drop",  32'(PSEL), 32'd0);

    // Read slot 1 with zero-wait slave: ready on edge 3
    mode = 0; PRDATA_bus[63:32] = 32'h0000_00A5;
    req = 1; addr = 32'h1000_1008; we = 0;
    tick(); req = 0;
    chk("t2_psel", 32'(PSEL), 32'h2);
    tick();
    chk("t2_rdy_early", 32'(ready), 32'd0);
    tick();
    chk("t2_ready", 32'(ready), 32'd1);
    chk("t2_rdata", rdata, 32'h0000_00A5);
    chk("t2_err",   32'(err), 32'd0);

    // Decode errors: slot beyond range and foreign region
    req = 1; addr = 32'h1000_7000;
    tick();
    chk("t3a_ready", 32'(ready), 32'd1);
    chk("t3a_err",   32'(err), 32'd1);
    chk("t3a_rdata", rdata, 32'd0);
    chk("t3a_psel",  32'(PSEL), 32'd0);
    addr = 32'h2000_0000;
    tick(); req = 0;
    chk("t3b_ready", 32'(ready), 32'd1);
    chk("t3b_err",   32'(err), 32'd1);
    chk("t3b_busy",  32'(busy), 32'd0);
    tick();
    chk("t3_pulse",  32'(ready), 32'd0);

    // Timeout: exactly TO access cycles then error completion
    mode = 2; req = 1; addr = 32'h1000_2010; we = 0;
    tick(); req = 0;
    cnt = 0; n = 0;
    while (!ready && n < 40) begin
      tick(); n++;
      if (PENABLE) cnt++;
    end
    chk("t4_cycles", 32'(cnt), 32'(TO));
    chk("t4_ready",  32'(ready), 32'd1);
    chk("t4_err",    32'(err), 32'd1);
    chk("t4_rdata",  rdata, 32'd0);
    chk("t4_psel",   32'(PSEL), 32'd0);
    chk("t4_pen",    32'(PENABLE), 32'd0);
    chk("t4_busy",   32'(busy), 32'd0);

    // Async reset in ACCESS, then a fresh read
    mode = 2; PRDATA_bus[127:96] = 32'h1234_5678;
    req = 1; addr = 32'h1000_3000; we = 0;
    tick(); req = 0;
    tick(); tick();
    chk("t5_in_access", 32'(PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("t5_psel", 32'(PSEL), 32'd0);
    chk("t5_pen",  32'(PENABLE), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (2) begin
      tick();
      chk("t5_no_ready", 32'(ready), 32'd0);
    end
    #2 PRESET = 1'b0;
    mode = 0; req = 1; addr = 32'h1000_3000; we = 0;
    tick(); req = 0;
    tick(); tick();
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_err",   32'(err), 32'd0);
    chk("t5_rdata", rdata, 32'h1234_5678);

    // req while busy ignored; req held through the ready cycle is accepted next edge
    mode = 1; req = 1; addr = 32'h1000_0040; we = 1; wdata = 32'h11;
    tick();
    addr = 32'h1000_2080; we = 0;
    tick();
    chk("t6_paddr_a1", PADDR, 32'h1000_0040);
    tick();
    chk("t6_paddr_a2", PADDR, 32'h1000_0040);
    tick();
    chk("t6_ready",    32'(ready), 32'd1);
    chk("t6_pwrite",   32'(PWRITE), 32'd1);
    tick(); req = 0;
    chk("t6_psel_b",   32'(PSEL), 32'h4);
    chk("t6_paddr_b",  PADDR, 32'h1000_2080);
    chk("t6_pen_b",    32'(PENABLE), 32'd0);
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    chk("t6_ready_b",  32'(ready), 32'd1);

    // Randomized traffic, garbage requests while busy, random slave timing
    rnd_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom)};
      else if (sel < 9) a = {16'h1000, 4'($urandom_range(NS, 15)), 12'($urandom)};
      else              a = 32'($urandom);
      sel = $urandom_range(0, 19);
      mode = (sel == 0) ? 2 : (sel < 7) ? 0 : (sel < 13) ? 1 : 3;
      req = 1; addr = a; we = 1'($urandom); wdata = 32'($urandom);
      tick();
      n = 0;
      while (!ready && n < 40) begin
        req = 1'($urandom); addr = 32'($urandom); we = 1'($urandom); wdata = 32'($urandom);
        tick(); n++;
      end
      if (!ready) chk("rand_ready_bound", 32'd0, 32'd1);
      req = 0;
    end
    rnd_en = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB initiator that converts single-word CPU-side bus requests into APB3 transfers toward the peripheral slaves (GPIO, timers, UART, ...).
It decodes the request address into one PSEL per slave and muxes that slave's PRDATA/PREADY back.
It also reports decode errors and a PREADY timeout to the requester.
It sits between the RV32I core's data-memory port and the APB peripheral bus.

Parameters:
NUM_SLAVES, 4, number of APB slave slots; legal range 1..16.
BASE_ADDR, 32'h1000_0000, peripheral region base; only bits [31:16] are compared.
TIMEOUT, 255, maximum ACCESS-phase cycles to wait for PREADY; legal range 2..65535.

Ports:
PCLK  input  1  APB clock; all logic is rising-edge.
PRESET  input  1  asynchronous, active-high reset.
req  input  1  request strobe; sampled only in IDLE.
addr  input  32  request byte address.
we  input  1  1 = write, 0 = read.
wdata  input  32  write data.
rdata  output  32  read data; valid when ready=1.
ready  output  1  one-cycle completion pulse.
err  output  1  qualifies ready; 1 = decode error or timeout.
busy  output  1  high whenever state != IDLE.
PADDR  output  32  latched address.
PWRITE  output  1  latched we.
PWDATA  output  32  latched wdata.
PSEL  output  NUM_SLAVES  one-hot slave select.
PENABLE  output  1  access phase.
PRDATA_bus  input  32*NUM_SLAVES  slave s read data at [32s+31:32s].
PREADY_bus  input  NUM_SLAVES  per-slave PREADY.

Behaviour:
- Reset (async, PRESET=1): state=IDLE; every output 0, including PADDR, PWDATA, PWRITE, PSEL, PENABLE, rdata, ready, err, busy.
- Reset mid-transfer aborts immediately; no ready pulse is generated for the aborted request.
- All outputs are registered or decoded from registered state; none is combinational from the inputs.
- Decode:
  - hit = (addr[31:16] == BASE_ADDR[31:16]) and (addr[15:12] < NUM_SLAVES).
  - slot = addr[15:12].
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE, req=1 and hit:
  - Latch PADDR=addr, PWRITE=we, PWDATA=wdata, slot.
  - Go to SETUP.
- IDLE, req=1 and not hit:
  - At the same edge, ready=1, err=1, rdata=0.
  - Stay in IDLE; no APB activity.
- SETUP: PSEL[slot]=1, PENABLE=0, for exactly one cycle; then go to ACCESS.
- ACCESS: PSEL[slot]=1, PENABLE=1. A wait counter is cleared on entry and increments each cycle.
  - PREADY_bus[slot]=1 at an edge:
    - ready=1, err=0.
    - rdata = PWRITE ? 0 : PRDATA_bus[slot].
    - Go to IDLE; PSEL and PENABLE drop at that edge.
  - PREADY low while wait counter == TIMEOUT-1:
    - ready=1, err=1, rdata=0.
    - Go to IDLE.
    - ACCESS therefore lasts at most TIMEOUT cycles.
- Only PREADY of the selected slot is observed; other slots' PREADY/PRDATA are ignored.
- ready and err are high for exactly one cycle per completion. rdata holds its value until the next completion.
- req while busy=1 is ignored and is not queued. The requester must wait for ready before issuing the next request.
- req in the cycle ready is high is accepted (state is IDLE), so back-to-back transfers are possible.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS; they retain their last values while IDLE.
- Latency with a slave that registers PREADY one cycle after PSEL&PENABLE:
  - req edge -> SETUP, next edge -> ACCESS, next edge -> slave PREADY=1, next edge -> ready=1.
  - Total is 4 PCLK edges.
  - Zero-wait slave (PREADY tied 1): 3 edges.

Test Plan:
1. Write to GPIO slot 0: req, addr=0x1000_0004, we=1, wdata=0xFF, slave registers PREADY -> PSEL=4'b0001 with PENABLE=0 for 1 cycle, then PENABLE=1 for 2 cycles; PADDR=0x1000_0004, PWDATA=0xFF stable throughout; ready=1, err=0 on edge 4.
2. Read slot 1: addr=0x1000_1008, we=0, PRDATA_bus slot 1 = 0x0000_00A5, PREADY tied 1 -> ready on edge 3, rdata=0xA5, err=0; PSEL=4'b0010 only.
3. Decode error: addr=0x1000_7000 (slot 7 ≥ NUM_SLAVES=4), and addr=0x2000_0000 -> ready=err=1 on the sampling edge, rdata=0, PSEL stays 0.
4. Timeout with TIMEOUT=16 and PREADY held 0 -> exactly 16 ACCESS cycles, then ready=err=1, rdata=0, PSEL/PENABLE=0, busy=0.
5. Async reset asserted during ACCESS -> PSEL, PENABLE, busy drop at once, no ready pulse; a fresh read after release completes normally.
6. req pulsed during SETUP/ACCESS is ignored (PADDR unchanged); a req asserted in the same cycle as ready starts a new SETUP on the next edge with the new address.
